// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the product accumulator slice.
package mul_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Working width of extend(); callers pad their product into it and slice
  // the acc_w result back out.
  localparam int unsigned MAX_W = 64;

  function automatic int unsigned acc_w_f(input int unsigned n, input int unsigned guard);
    return 2 * n + guard;
  endfunction

  // Sign- or zero-extend the low prod_w bits of prod to the full MAX_W width.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] prod,
                                              input int unsigned prod_w,
                                              input logic is_signed);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top_bit;
    logic             msb;
    mask    = ~({MAX_W{1'b1}} << prod_w);
    top_bit = {{(MAX_W-1){1'b0}}, 1'b1} << (prod_w - 1);
    msb     = |(prod & top_bit);
    return (is_signed && msb) ? (prod | ~mask) : (prod & mask);
  endfunction

endpackage

// File: rtl/mul_product_accumulator_if.sv
// Product stream in, group result out, both valid/ready.
interface mul_product_accumulator_if
  import mul_acc_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned guard = 4
);
  localparam int unsigned acc_w = acc_w_f(n, guard);

  logic             up_valid;
  logic             up_ready;
  logic [2*n-1:0]   up_prod;
  logic             up_signed;
  logic             up_last;
  logic             down_valid;
  logic             down_ready;
  logic [acc_w-1:0] down_sum;
  logic             down_signed;
  logic [guard:0]   down_count;
  logic             down_ovf;

  modport master (
    output up_valid, up_prod, up_signed, up_last, down_ready,
    input  up_ready, down_valid, down_sum, down_signed, down_count, down_ovf
  );

  modport slave (
    input  up_valid, up_prod, up_signed, up_last, down_ready,
    output up_ready, down_valid, down_sum, down_signed, down_count, down_ovf
  );

endinterface

// File: rtl/product_extend.sv
// Combinational sign/zero extension of a 2n-bit product to the accumulator width.
module product_extend
  import mul_acc_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned guard = 4
) (
  input  logic [2*n-1:0]                 prod,
  input  logic                           is_signed,
  output logic [acc_w_f(n, guard)-1:0]   ext
);
  localparam int unsigned acc_w = acc_w_f(n, guard);

  logic [MAX_W-1:0] full;
  logic             unused_hi;

  // Extend through the package helper at its fixed width, keep the low acc_w bits.
  always_comb begin
    full      = extend({{(MAX_W-2*n){1'b0}}, prod}, 2 * n, is_signed);
    ext       = full[acc_w-1:0];
    unused_hi = ^full[MAX_W-1:acc_w];
  end

endmodule

// File: rtl/mul_product_accumulator.sv
// Accumulates groups of extended products and presents each group's sum.
module mul_product_accumulator
  import mul_acc_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned guard = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  mul_product_accumulator_if.slave     bus
);
  localparam int unsigned acc_w = acc_w_f(n, guard);
  localparam logic [guard:0] cnt_max   = '1;
  localparam logic [guard:0] cnt_limit = {1'b1, {guard{1'b0}}};
  localparam logic [guard:0] cnt_one   = {{guard{1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [acc_w-1:0] acc, acc_next, ext;
  logic [guard:0]   cnt, cnt_next;
  logic             first, mode, ovf;
  logic             mode_next, ovf_next, beat;

  logic             down_valid_q, down_signed_q, down_ovf_q;
  logic [acc_w-1:0] down_sum_q;
  logic [guard:0]   down_count_q;

  // The first beat's mode must already steer its own extension.
  product_extend #(.n(n), .guard(guard)) u_extend (
    .prod      (bus.up_prod),
    .is_signed (mode_next),
    .ext       (ext)
  );

  // Post-update accumulator values for an accepted beat, plus FSM next state.
  always_comb begin
    beat      = bus.up_valid && (state == ACCUM);
    mode_next = first ? bus.up_signed : mode;
    if (first) begin
      acc_next = ext;
      cnt_next = cnt_one;
      ovf_next = 1'b0;
    end else begin
      acc_next = acc + ext;
      cnt_next = (cnt == cnt_max) ? cnt : cnt + cnt_one;
      ovf_next = ovf;
    end
    if (cnt_next > cnt_limit) ovf_next = 1'b1;
    state_next = state;
    case (state)
      ACCUM: if (beat && bus.up_last) state_next = DONE;
      DONE:  if (bus.down_ready)      state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // FSM, accumulator and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      first         <= 1'b1;
      mode          <= 1'b0;
      ovf           <= 1'b0;
      down_valid_q  <= 1'b0;
      down_sum_q    <= '0;
      down_signed_q <= 1'b0;
      down_count_q  <= '0;
      down_ovf_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ACCUM: begin
          if (beat) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            first <= 1'b0;
            mode  <= mode_next;
            ovf   <= ovf_next;
            if (bus.up_last) begin
              down_valid_q  <= 1'b1;
              down_sum_q    <= acc_next;
              down_signed_q <= mode_next;
              down_count_q  <= cnt_next;
              down_ovf_q    <= ovf_next;
            end
          end
        end
        DONE: begin
          if (bus.down_ready) begin
            down_valid_q <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            first        <= 1'b1;
            mode         <= 1'b0;
            ovf          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.up_ready    = (state == ACCUM);
  assign bus.down_valid  = down_valid_q;
  assign bus.down_sum    = down_sum_q;
  assign bus.down_signed = down_signed_q;
  assign bus.down_count  = down_count_q;
  assign bus.down_ovf    = down_ovf_q;

endmodule

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
Downstream consumer of the signed-or-unsigned multiplier stage. Takes a stream of 2n-bit products, each tagged signed or unsigned, over a valid/ready handshake. It sign- or zero-extends each product and accumulates a group of them, closed by a "last" marker, into a wider guarded sum. The finished dot-product result is presented on a second valid/ready interface with a term count and an overflow flag.

Parameters:
n, 8, operand width of the upstream multiplier; each product is 2n bits
guard, 4, guard bits; at most 2^guard terms per group are summed exactly
acc_w, 2*n+guard, derived localparam; not overridable; accumulator and result width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
up_valid  input  1  product beat valid
up_ready  output  1  block accepts a beat this cycle
up_prod  input  2n  raw product bits from the multiplier
up_signed  input  1  1: up_prod is two's complement; 0: unsigned
up_last  input  1  beat closes the current group
down_valid  output  1  result valid
down_ready  input  1  consumer accepts result
down_sum  output  acc_w  accumulated group sum
down_signed  output  1  signedness of the group
down_count  output  guard+1  number of terms in the group, saturating at 2^(guard+1)-1
down_ovf  output  1  group had more than 2^guard terms; down_sum has wrapped modulo 2^acc_w

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. No other clock or reset.
- Reset state is ACCUM. Reset values: down_valid=0, down_sum=0, down_signed=0, down_count=0, down_ovf=0. Internal accumulator, count, first-beat flag, sign mode and overflow flag are cleared.
- Reset during a partial group discards that group. The next accepted beat starts a fresh group.
- Reset while in DONE drops the pending result: down_valid=0 in the cycle after rst.
- The FSM has two states, ACCUM and DONE.
- ACCUM behaviour:
  - up_ready=1 and down_valid=0.
  - A beat is accepted when up_valid && up_ready.
  - ext = sign-extend(up_prod) to acc_w if the group's mode is signed, else zero-extend.
  - The first beat of a group latches the mode from its up_signed. up_signed on later beats of the same group is ignored.
  - First beat: acc <= ext, count <= 1. Later beats: acc <= acc + ext, wrapping modulo 2^acc_w. count increments and saturates.
  - ovf sets, and stays set, on the beat that makes count exceed 2^guard.
  - Accepted beat with up_last=1: down_sum, down_signed, down_count and down_ovf are loaded with the post-update values; next state is DONE.
  - A single-beat group (up_last on its first beat) is legal.
  - Cycles with up_valid=0 leave all state unchanged.
- DONE behaviour:
  - down_valid=1 and up_ready=0; up_valid is ignored.
  - Outputs hold stable for as long as down_ready=0.
  - On down_valid && down_ready the next state is ACCUM. down_valid drops and the internal accumulator state is cleared.
  - down_sum and the other result outputs keep their last values until the next result loads.
- Latency: down_valid rises in the cycle after the last beat is accepted.
- Throughput: one product per clock within a group. There is at least one bubble cycle per group, because up_ready=0 in DONE.
- Exactness: for group length ≤ 2^guard, the sum of n-bit×n-bit products fits acc_w exactly in both modes.
- All registers use non-blocking assignment in a single clocked process. The FSM next-state logic is combinational.

Decomposition:
- Package mul_acc_pkg holds:
  - the state enum {ACCUM, DONE};
  - a function acc_w_f(n, guard);
  - a function extend(prod, signed) that returns an acc_w value.
- One sub-module is natural: product_extend, a combinational sign/zero extender parameterised by n and guard. The FSM and accumulator stay in the top module.

Test Plan:
Unless stated otherwise, all scenarios run with n=8, guard=4, acc_w=20 and down_ready=1.
1. Unsigned group of 3 beats 0xFE01, up_signed=0, last on the 3rd beat -> down_sum=0x2FA03, down_count=3, down_ovf=0, down_signed=0. down_valid rises 1 cycle after the 3rd beat.
2. Signed group 0xFF80, 0x4000 -> down_sum=0x03F80. Signed group 0xFFFF, 0xFFFF -> down_sum=0xFFFFE. The same two 0xFFFF beats unsigned -> down_sum=0x1FFFE.
3. Backpressure: complete a group, hold down_ready=0 for 5 cycles while driving up_valid=1 -> down_valid stays 1, down_sum is stable, up_ready=0 and no beat is consumed. Raise down_ready -> up_ready=1 the next cycle.
4. Overflow: 17 unsigned beats of 0xFE01 -> down_ovf=1, down_count=17, down_sum=0x0DE11. A following 16-beat group -> down_ovf=0, down_sum=0xFE010.
5. Mode latch and gaps: first beat 0xFFFF with up_signed=1, second beat 0x0001 with up_signed=0 and up_last, with 3 idle cycles between the beats -> down_signed=1, down_sum=0x00000, down_count=2.
6. Reset: accept 2 beats of 0x0100, assert rst for 1 cycle, then send a single beat 0x0005 with up_last -> down_sum=0x00005, down_count=1. Also assert rst in DONE -> down_valid=0 and all outputs are 0 the next cycle.
